link_scheduler: RTL and testbench
=================================

LINK_SCHEDULER -- requirements
Module: link_scheduler

Interface
REQ-001 Parameter NCH, default 4, number of independent protocol channels (1..8).
REQ-002 Parameter TIMEOUT_CYC, default 1024, watchdog limit in cycles without i_done while CONNECTED or LINKED (2..65535).
REQ-003 Parameter LINK_EN, default 1, 1 allows o_link assertion in LINKED, 0 forces o_link low.
REQ-004 i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_done  input  NCH  per-channel completion pulse from protocol engine; bit n belongs to channel n.
REQ-007 i_tmo_clr  input  1  clears all sticky timeout flags.
REQ-008 o_send  output  NCH  one-cycle send strobe to channel n; at most one bit high per cycle.
REQ-009 o_link  output  NCH  channel n in LINKED and LINK_EN=1.
REQ-010 o_link_cnt  output  clog2(NCH+1)  population count of o_link.
REQ-011 o_tmo  output  NCH  sticky flag, channel n watchdog expired.

Function
REQ-012 Per channel: FSM states IDLE=0, CONNECTED=1, LINKED=2; encoding 3 unused, decodes to IDLE next cycle.
REQ-013 IDLE + i_done[n] -> CONNECTED, set pend[n], clear wdog[n].
REQ-014 CONNECTED + i_done[n] -> LINKED, clear wdog[n]; no new send request.
REQ-015 LINKED + i_done[n] -> CONNECTED, set pend[n], clear wdog[n], o_link[n] low from next cycle.
REQ-016 CONNECTED or LINKED without i_done[n]: wdog[n] increments by 1 per cycle, saturating; wdog[n]==TIMEOUT_CYC-1 with no i_done[n] -> IDLE, clear pend[n], set o_tmo[n], clear wdog[n].
REQ-017 i_done[n] in the same cycle as watchdog expiry: i_done wins, transition per REQ-014/015, o_tmo[n] unchanged.
REQ-018 IDLE: wdog[n] held at 0; no timeout possible.
REQ-019 Arbiter: each cycle, if any pend bit set, grant exactly one channel, round-robin starting at (last_grant+1) mod NCH; last_grant resets to NCH-1 so channel 0 has first priority.
REQ-020 Grant: o_send[g] high for exactly the next cycle, pend[g] cleared in that same cycle, last_grant <= g.
REQ-021 Latency: i_done in IDLE/LINKED at cycle t with no contention -> o_send at t+2 (pend set t+1, strobe t+2).
REQ-022 Worst-case send latency NCH+1 cycles after pend set.
REQ-023 pend[n] already set and new i_done[n] requesting again: remains single request; no double strobe.
REQ-024 Pending channel that times out (REQ-016) never receives o_send for that request.
REQ-025 o_link[n] registered: high in every cycle channel n state is LINKED and LINK_EN=1.
REQ-026 o_link_cnt registered, consistent with o_link of the same cycle.
REQ-027 o_tmo[n] set by expiry, cleared by i_tmo_clr; simultaneous set and clear -> set wins.
REQ-028 Channels fully independent except for shared arbiter; no combinational path from inputs to outputs.

Reset
REQ-029 i_rst high at a clock edge: all channels IDLE, pend=0, wdog=0, last_grant=NCH-1, o_send=0, o_link=0, o_link_cnt=0, o_tmo=0 from next cycle.
REQ-030 Reset mid-operation (pending grant, running watchdog) aborts all activity; no o_send strobe in the cycle after reset.
REQ-031 i_done sampled during reset is ignored.

Verification (NCH=4, TIMEOUT_CYC=16, LINK_EN=1)
REQ-032 Single channel handshake: i_done[0] at t0 -> o_send=4'b0001 at t0+2 only; i_done[0] at t5 -> o_link=4'b0001, o_link_cnt=1 from t6.
REQ-033 Contention: i_done=4'b1111 in one cycle from IDLE -> o_send strobes 0001,0010,0100,1000 on four consecutive cycles, no gaps, no repeats.
REQ-034 Watchdog: channel 2 LINKED, no i_done for 16 cycles -> state IDLE, o_link[2]=0, o_tmo=4'b0100; i_tmo_clr -> o_tmo=0 next cycle.
REQ-035 Tie: i_done[1] on exact expiry cycle of channel 1 in CONNECTED -> LINKED, o_tmo[1]=0.
REQ-036 Reset mid-arbitration: i_done=4'b0110, i_rst asserted next cycle -> o_send stays 0, all outputs 0; subsequent i_done[3] -> o_send=4'b1000 two cycles later.
REQ-037 LINK_EN=0 build: full handshake to LINKED -> o_link=0, o_link_cnt=0 throughout.

Source files
------------

// File: rtl/link_scheduler.sv
// Per-channel IDLE/CONNECTED/LINKED handshake trackers with watchdogs, feeding
// a shared round-robin arbiter that issues one-cycle send strobes.
module link_scheduler #(
   parameter int unsigned NCH         = 4,
   parameter int unsigned TIMEOUT_CYC = 1024,
   parameter int unsigned LINK_EN     = 1
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic [NCH-1:0]               i_done,
   input  logic                         i_tmo_clr,
   output logic [NCH-1:0]               o_send,
   output logic [NCH-1:0]               o_link,
   output logic [$clog2(NCH+1)-1:0]     o_link_cnt,
   output logic [NCH-1:0]               o_tmo
);

   localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned SW = GW + 1;
   localparam int unsigned CW = $clog2(NCH + 1);
   localparam int unsigned WW = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONN = 2'd1,
      ST_LINK = 2'd2
   } state_t;

   state_t          state_q [NCH];
   state_t          state_d [NCH];
   logic [WW-1:0]   wdog_q  [NCH];
   logic [WW-1:0]   wdog_d  [NCH];
   logic [NCH-1:0]  pend_q;
   logic [NCH-1:0]  pend_d;
   logic [NCH-1:0]  pend_set;
   logic [NCH-1:0]  expire;
   logic [NCH-1:0]  avail;
   logic [NCH-1:0]  grant;
   logic [NCH-1:0]  rot;
   logic [NCH-1:0]  link_d;
   logic [NCH-1:0]  tmo_d;
   logic [GW-1:0]   last_q;
   logic [GW-1:0]   last_d;
   logic [GW-1:0]   gsel;
   logic [SW-1:0]   sh;
   logic [CW-1:0]   cnt_d;
   logic            found;
   int unsigned     off;

   // State register: channel FSMs, watchdogs, request flags, arbiter pointer, outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int n = 0; n < NCH; n++) begin
            state_q[n] <= ST_IDLE;
            wdog_q[n]  <= '0;
         end
         pend_q     <= '0;
         last_q     <= GW'(NCH - 1);
         o_send     <= '0;
         o_link     <= '0;
         o_link_cnt <= '0;
         o_tmo      <= '0;
      end else begin
         for (int n = 0; n < NCH; n++) begin
            state_q[n] <= state_d[n];
            wdog_q[n]  <= wdog_d[n];
         end
         pend_q     <= pend_d;
         last_q     <= last_d;
         o_send     <= grant;
         o_link     <= link_d;
         o_link_cnt <= cnt_d;
         o_tmo      <= tmo_d;
      end
   end

   // Next-state: channel transitions, watchdog, arbitration and output values
   always_comb begin
      pend_set = '0;
      expire   = '0;
      link_d   = '0;
      cnt_d    = '0;
      found    = 1'b0;
      off      = 0;
      for (int n = 0; n < NCH; n++) begin
         state_d[n] = state_q[n];
         wdog_d[n]  = wdog_q[n];
      end

      for (int n = 0; n < NCH; n++) begin
         case (state_q[n])
            ST_IDLE: begin
               wdog_d[n] = '0;
               if (i_done[n]) begin
                  state_d[n]  = ST_CONN;
                  pend_set[n] = 1'b1;
               end
            end
            ST_CONN, ST_LINK: begin
               // A completion pulse beats a coincident watchdog expiry
               if (i_done[n]) begin
                  state_d[n]  = (state_q[n] == ST_CONN) ? ST_LINK : ST_CONN;
                  pend_set[n] = (state_q[n] == ST_LINK);
                  wdog_d[n]   = '0;
               end else if (wdog_q[n] == WW'(TIMEOUT_CYC - 1)) begin
                  state_d[n] = ST_IDLE;
                  expire[n]  = 1'b1;
                  wdog_d[n]  = '0;
               end else if (wdog_q[n] != '1) begin
                  wdog_d[n] = wdog_q[n] + WW'(1);
               end
            end
            default: begin
               state_d[n] = ST_IDLE;
               wdog_d[n]  = '0;
            end
         endcase
      end

      // Expiring channels drop their request before it can be granted
      avail = pend_q & ~expire;
      sh    = SW'(last_q) + SW'(1);
      rot   = NCH'({avail, avail} >> sh);
      for (int i = 0; i < NCH; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = i;
         end
      end
      gsel   = GW'((32'(sh) + off) % NCH);
      grant  = found ? (NCH'(1) << gsel) : '0;
      last_d = found ? gsel : last_q;
      pend_d = (avail & ~grant) | pend_set;

      tmo_d = (i_tmo_clr ? '0 : o_tmo) | expire;

      for (int n = 0; n < NCH; n++) begin
         link_d[n] = (state_d[n] == ST_LINK) && (LINK_EN != 0);
         cnt_d     = cnt_d + CW'(link_d[n]);
      end
   end

endmodule

// File: tb/tb_link_scheduler.sv
// Directed bench for link_scheduler (NCH=4, TIMEOUT_CYC=16) with a LINK_EN=0
// twin driven by the same stimulus.
module tb_link_scheduler;

   logic       clk;
   logic       rst;
   logic [3:0] done;
   logic       tmo_clr;
   logic [3:0] send,    link,    tmo;
   logic [2:0] link_cnt;
   logic [3:0] nl_send, nl_link, nl_tmo;
   logic [2:0] nl_link_cnt;

   int vectors;
   int miscompares;

   link_scheduler #(.NCH(4), .TIMEOUT_CYC(16), .LINK_EN(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_done(done), .i_tmo_clr(tmo_clr),
      .o_send(send), .o_link(link), .o_link_cnt(link_cnt), .o_tmo(tmo)
   );

   link_scheduler #(.NCH(4), .TIMEOUT_CYC(16), .LINK_EN(0)) dut_nl (
      .i_clk(clk), .i_rst(rst), .i_done(done), .i_tmo_clr(tmo_clr),
      .o_send(nl_send), .o_link(nl_link), .o_link_cnt(nl_link_cnt), .o_tmo(nl_tmo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      done = 4'b0000;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst     = 1'b1;
      done    = 4'b0000;
      tmo_clr = 1'b0;
      tick(2);
      chk("rst_send", 32'(send), 32'h0);
      chk("rst_link", 32'(link), 32'h0);
      chk("rst_cnt",  32'(link_cnt), 32'h0);
      chk("rst_tmo",  32'(tmo), 32'h0);
      rst = 1'b0;

      // Single-channel handshake
      done = 4'b0001; tick(); done = 4'b0000;
      chk("hs_send_t1", 32'(send), 32'h0);
      tick();
      chk("hs_send_t2", 32'(send), 32'h1);
      tick();
      chk("hs_send_t3", 32'(send), 32'h0);
      done = 4'b0001; tick(); done = 4'b0000;
      chk("hs_link",    32'(link), 32'h1);
      chk("hs_cnt",     32'(link_cnt), 32'h1);
      chk("hs_nl_link", 32'(nl_link), 32'h0);
      chk("hs_nl_cnt",  32'(nl_link_cnt), 32'h0);
      tick();
      chk("hs_no_resend", 32'(send), 32'h0);
      chk("hs_link_hold", 32'(link), 32'h1);
      // Relink request from LINKED drops o_link and requests a new send
      done = 4'b0001; tick(); done = 4'b0000;
      chk("relink_link", 32'(link), 32'h0);
      chk("relink_cnt",  32'(link_cnt), 32'h0);
      tick();
      chk("relink_send", 32'(send), 32'h1);

      // Full contention from IDLE
      do_reset();
      chk("post_rst_link", 32'(link), 32'h0);
      done = 4'b1111; tick(); done = 4'b0000;
      chk("cont_t1", 32'(send), 32'h0);
      tick(); chk("cont_g0", 32'(send), 32'h1);
      tick(); chk("cont_g1", 32'(send), 32'h2);
      tick(); chk("cont_g2", 32'(send), 32'h4);
      tick(); chk("cont_g3", 32'(send), 32'h8);
      tick(); chk("cont_end", 32'(send), 32'h0);

      // Round-robin resumes after the last grant
      do_reset();
      done = 4'b0100; tick(); done = 4'b0000;
      tick(); chk("rr_first", 32'(send), 32'h4);
      done = 4'b1011; tick(); done = 4'b0000;
      tick(); chk("rr_g3", 32'(send), 32'h8);
      tick(); chk("rr_g0", 32'(send), 32'h1);
      tick(); chk("rr_g1", 32'(send), 32'h2);
      tick(); chk("rr_end", 32'(send), 32'h0);

      // Watchdog expiry from LINKED, then sticky clear
      do_reset();
      done = 4'b0100; tick(); done = 4'b0000;
      tick(); chk("wd_send", 32'(send), 32'h4);
      done = 4'b0100; tick(); done = 4'b0000;
      chk("wd_linked", 32'(link), 32'h4);
      tick(15);
      chk("wd_still_link", 32'(link), 32'h4);
      chk("wd_no_tmo_yet", 32'(tmo), 32'h0);
      tick();
      chk("wd_link_drop", 32'(link), 32'h0);
      chk("wd_cnt_drop",  32'(link_cnt), 32'h0);
      chk("wd_tmo",       32'(tmo), 32'h4);
      chk("wd_nl_tmo",    32'(nl_tmo), 32'h4);
      tmo_clr = 1'b1; tick(); tmo_clr = 1'b0;
      chk("wd_tmo_clr", 32'(tmo), 32'h0);

      // Completion on the exact expiry cycle wins over the watchdog
      do_reset();
      done = 4'b0010; tick(); done = 4'b0000;
      tick(15);
      chk("tie_pre_tmo", 32'(tmo), 32'h0);
      done = 4'b0010; tick(); done = 4'b0000;
      chk("tie_link", 32'(link), 32'h2);
      chk("tie_tmo",  32'(tmo), 32'h0);

      // Reset in the middle of arbitration
      do_reset();
      done = 4'b0110; tick(); done = 4'b0000;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("mid_rst_send", 32'(send), 32'h0);
      chk("mid_rst_link", 32'(link), 32'h0);
      chk("mid_rst_cnt",  32'(link_cnt), 32'h0);
      chk("mid_rst_tmo",  32'(tmo), 32'h0);
      tick();
      chk("mid_rst_after", 32'(send), 32'h0);
      done = 4'b1000; tick(); done = 4'b0000;
      chk("mid_rst_t1", 32'(send), 32'h0);
      tick();
      chk("mid_rst_g3", 32'(send), 32'h8);
      chk("mid_rst_nl_g3", 32'(nl_send), 32'h8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
